// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types for the sequential RV32M multiplier.
//   mul_op_t    : operation select, encoded as funct3[1:0]
//   mul_state_t : multiplier control states
//   mul_ctl_t   : per-operation control latched on accept
//   cnt_width() : width of the iteration counter for a given operand width
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_LO = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    typedef struct packed {
        mul_op_t op;
        logic    neg;   // product must be negated in SIGN
    } mul_ctl_t;

    // Counter covers 0..width-1, i.e. $clog2(width) bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Request/response bundle of the sequential multiplier.
//   request : in_valid/in_ready, op, operand_a, operand_b, flush
//   response: out_valid/out_ready, result, busy
//   master  : execute-stage control path driving operations in
//   slave   : the multiplier
// ---------------------------------------------------------------------------
interface seq_multiplier_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    mul_op_t          op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, operand_a, operand_b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
// Common combinational adder: sum = a + b + cin (carry-out dropped).
//   a, b : WIDTH-bit addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
// ---------------------------------------------------------------------------
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes one multiplier bit per cycle, then fixes the
// sign in a single extra cycle and presents the selected product half.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_multiplier_if.slave (operation in, result out, flush, busy)
// An operation accepted in cycle k presents its result from cycle k+WIDTH+2;
// with out_ready held high a new operation can be taken every WIDTH+3 cycles.
// ---------------------------------------------------------------------------
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    seq_multiplier_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    mul_state_t         state, state_nx;
    mul_ctl_t           ctl_q;
    logic [WIDTH-1:0]   a_mag_q;
    logic [2*WIDTH:0]   p_q;        // {hi (WIDTH+1), lo (WIDTH)}
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q;

    logic               accept;
    logic               handoff;
    logic               last_iter;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     hi_nx;
    logic [2*WIDTH-1:0] neg_sum;
    logic [2*WIDTH-1:0] product;

    assign bus.in_ready  = (state == IDLE) && !bus.flush;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign handoff   = out_valid_q && bus.out_ready;
    assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

    // Effective signs: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    // The magnitude of the most negative value fits unsigned in WIDTH bits.
    assign sign_a = ((bus.op == MULH) || (bus.op == MULHSU)) && bus.operand_a[WIDTH-1];
    assign sign_b = (bus.op == MULH) && bus.operand_b[WIDTH-1];
    assign a_abs  = sign_a ? -bus.operand_a : bus.operand_a;
    assign b_abs  = sign_b ? -bus.operand_b : bus.operand_b;

    // Partial-product accumulator: hi + {0,|a|}, one extra bit so the carry
    // survives until the following right shift.
    adder #(.WIDTH(WIDTH+1)) u_acc (
        .a   (p_q[2*WIDTH:WIDTH]),
        .b   ({1'b0, a_mag_q}),
        .cin (1'b0),
        .sum (acc_sum)
    );

    assign hi_nx = p_q[0] ? acc_sum : p_q[2*WIDTH:WIDTH];

    // Two's complement of the finished product as ~P + 1.
    adder #(.WIDTH(2*WIDTH)) u_neg (
        .a   (~p_q[2*WIDTH-1:0]),
        .b   ({(2*WIDTH){1'b0}}),
        .cin (1'b1),
        .sum (neg_sum)
    );

    assign product = ctl_q.neg ? neg_sum : p_q[2*WIDTH-1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)    state_nx = RUN;
                RUN:     if (last_iter) state_nx = SIGN;
                SIGN:                   state_nx = DONE;
                DONE:    if (handoff)   state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctl_q       <= '{op: MUL_LO, neg: 1'b0};
            a_mag_q     <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                ctl_q.op  <= bus.op;
                ctl_q.neg <= sign_a ^ sign_b;
                a_mag_q   <= a_abs;
                p_q       <= {{(WIDTH+1){1'b0}}, b_abs};
                cnt_q     <= '0;
            end else if (state == RUN) begin
                p_q   <= {1'b0, hi_nx, p_q[WIDTH-1:1]};
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // The sign-corrected product is folded straight into the result
            // register on the SIGN edge, so DONE presents it immediately.
            if (bus.flush || handoff) begin
                out_valid_q <= 1'b0;
            end else if (state == SIGN) begin
                out_valid_q <= 1'b1;
                result_q    <= (ctl_q.op == MUL_LO) ? product[WIDTH-1:0]
                                                    : product[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier implementing the RV32M MUL, MULH, MULHSU and MULHU operations.
- Sits beside the ALU in the execute stage. It instantiates the common `adder` as its partial-product accumulator and consumes that adder's result every iteration.
- Operands arrive and results leave over valid/ready handshakes, so the control path can stall on it.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept a new operation.
- op  input  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- operand_a  input  WIDTH  multiplicand (rs1).
- operand_b  input  WIDTH  multiplier (rs2).
- flush  input  1  synchronous abort of any operation in flight.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  low or high half of the product, selected by op.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE, out_valid=0, result=0, busy=0, in_ready=1 once reset is released.
  - Reset during RUN/SIGN/DONE discards the operation; no partial result ever appears.
- States: IDLE, RUN, SIGN, DONE.
- in_ready = (state==IDLE) && !flush. An operation is accepted on a rising edge where in_valid && in_ready.
- On accept:
  - Latch op.
  - Latch the magnitudes |a| and |b|. a is signed for MULH/MULHSU; b is signed for MULH only; all other cases are unsigned.
  - Latch neg = sign_a XOR sign_b, using effective signs only.
  - Initialise product register P (2*WIDTH+1 bits) as hi=0 (WIDTH+1 bits), lo=|b|. Set count=0. Go to RUN.
- RUN, once per cycle:
  - If lo[0]=1, hi = hi + {0,|a|} through an adder instance of width WIDTH+1.
  - Then P is shifted right by 1 and count increments.
  - After the WIDTH-th iteration (count==WIDTH-1 on that edge), go to SIGN.
- SIGN, one cycle: if neg, the 2*WIDTH product becomes its two's complement, computed as ~P+1 with a second adder instance of width 2*WIDTH. Go to DONE.
- DONE:
  - out_valid=1. result = low WIDTH bits for MUL, high WIDTH bits otherwise.
  - result and out_valid are registered and held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid falls the next cycle.
- Latency: out_valid rises exactly WIDTH+2 cycles after the accept edge (34 for WIDTH=32). Throughput is one operation per WIDTH+3 cycles when out_ready is held high.
- The next operation cannot be accepted in the same cycle as result handoff; in_ready rises the cycle after.
- flush=1:
  - From any state, go to IDLE on the next edge and clear out_valid.
  - A flush coinciding with in_valid does not accept.
  - A flush coinciding with out_ready in DONE counts as a completed handoff; the result is not re-presented.
- Operand changes after accept have no effect.
- Arithmetic corner cases:
  - The magnitude of the most negative value, 0x80000000, is carried unsigned in WIDTH bits, so there is no overflow.
  - A zero operand with neg=1 yields 0, since the two's complement of 0 is 0.

Decomposition:
- Package mul_pkg holds:
  - mul_op_t enum (MUL_LO=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - mul_state_t enum (IDLE, RUN, SIGN, DONE).
  - Iteration counter width constant, $clog2(WIDTH).
- Sub-modules: reuse the existing `adder` module, two instances (WIDTH+1 accumulator and 2*WIDTH negator). No new sub-module is required.

Test Plan:
- MUL, a=7, b=6 -> result 0x0000002A. out_valid rises 34 cycles after accept and stays high while out_ready=0 for 5 cycles.
- MULH, a=0xFFFFFFFF (-1), b=0xFFFFFFFF (-1) -> result 0x00000000. MUL on the same operands -> 0x00000001.
- MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU on the same operands -> 0xFFFFFFFF.
- MULH, a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU, a=0x80000000, b=2 -> 0xFFFFFFFF.
- Back-to-back with out_ready=1:
  - Two accepts are 35 cycles apart.
  - in_ready=0 throughout RUN/SIGN/DONE.
  - Operands changed mid-RUN do not alter the result.
- Abort and reset handling:
  - flush asserted in RUN at iteration 10 -> IDLE next cycle, out_valid never rises, in_ready=1 the following cycle.
  - Asynchronous reset pulse mid-RUN -> out_valid=0, result=0, busy=0 immediately.
